shift_out_ctrl: RTL and testbench



---
 rtl/shift_out_ctrl_pkg.sv | 12 +
 rtl/shift_out_ctrl_if.sv | 23 ++
 rtl/shift_out_ctrl_shift_reg.sv | 34 +++
 rtl/shift_out_ctrl.sv | 119 +++++++++++
 tb/tb_shift_out_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/shift_out_ctrl_pkg.sv
// rtl/shift_out_ctrl_pkg.sv - shared state encodings and default sizing for shift_out_ctrl
package shift_out_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/shift_out_ctrl_if.sv
// rtl/shift_out_ctrl_if.sv - load handshake and serial output bundle for shift_out_ctrl
interface shift_out_ctrl_if import shift_out_ctrl_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             abort;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, abort,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, abort,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/shift_out_ctrl_shift_reg.sv
// rtl/shift_out_ctrl_shift_reg.sv - parallel-load, MSB-first shift bank
module shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             clear,
  output logic             msb
);
  logic [WIDTH-1:0] data_q, data_d;

  // clear (abort) outranks load; the controller never asserts both
  always_comb begin
    data_d = data_q;
    if (clear)
      data_d = '0;
    else if (load)
      data_d = load_data;
    else if (shift_en)
      data_d = {data_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      data_q <= '0;
    else
      data_q <= data_d;
  end

  assign msb = data_q[WIDTH-1];
endmodule

// File: rtl/shift_out_ctrl.sv
// rtl/shift_out_ctrl.sv - handshake-fed PISO sequencer; SHIFT_OUT_CTRL_PARITY_EN appends an even-parity bit
module shift_out_ctrl import shift_out_ctrl_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          clr_n,
  shift_out_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             sr_load, sr_shift, sr_clear, sr_msb;
  logic             sout, sout_valid, busy, done;
`ifdef SHIFT_OUT_CTRL_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bus.load_ready = (state_q == S_IDLE) & clr_n;
  assign accept         = bus.load_valid & bus.load_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    sr_clear   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
`ifdef SHIFT_OUT_CTRL_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_load = 1'b1;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = S_SHIFT;
`ifdef SHIFT_OUT_CTRL_PARITY_EN
          par_d   = ^bus.load_data;
`endif
        end
      end
      S_SHIFT: begin
        sout       = sr_msb;
        sout_valid = 1'b1;
        busy       = 1'b1;
        if (bus.abort) begin
          sr_clear = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          sr_shift = 1'b1;
          if (cnt_q == '0) begin
`ifdef SHIFT_OUT_CTRL_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
`ifdef SHIFT_OUT_CTRL_PARITY_EN
      S_PARITY: begin
        sout       = par_q;
        sout_valid = 1'b1;
        busy       = 1'b1;
        if (bus.abort) begin
          sr_clear = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
`ifdef SHIFT_OUT_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SHIFT_OUT_CTRL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk       (clk),
    .clr_n     (clr_n),
    .load      (sr_load),
    .load_data (bus.load_data),
    .shift_en  (sr_shift),
    .clear     (sr_clear),
    .msb       (sr_msb)
  );

  assign bus.sout       = sout;
  assign bus.sout_valid = sout_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;
endmodule

// File: tb/tb_shift_out_ctrl.sv
// tb/tb_shift_out_ctrl.sv - directed self-checking bench for shift_out_ctrl
module tb_shift_out_ctrl;
  logic clk;
  logic clr_n;
  int   n_cmp;
  int   n_err;

  shift_out_ctrl_if #(.WIDTH(8)) bus ();

  shift_out_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE; ends at the negedge where load_ready has returned.
  task automatic xfer(input logic [7:0] w, input bit keep_ff, input bit abort_first);
    chk("xf_ready_idle", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    bus.abort      = abort_first;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.abort = 1'b0;
      if (keep_ff)
        bus.load_data = 8'hFF;
      else
        bus.load_valid = 1'b0;
      chk("xf_sout", bus.sout, w[7-i]);
      chk("xf_sout_valid", bus.sout_valid, 1);
      chk("xf_busy", bus.busy, 1);
      chk("xf_ready_busy", bus.load_ready, 0);
      chk("xf_no_done", bus.done, 0);
    end
`ifdef SHIFT_OUT_CTRL_PARITY_EN
    @(negedge clk);
    chk("xf_parity", bus.sout, ^w);
    chk("xf_parity_valid", bus.sout_valid, 1);
    chk("xf_parity_no_done", bus.done, 0);
`endif
    @(negedge clk);
    chk("xf_done", bus.done, 1);
    chk("xf_done_busy", bus.busy, 1);
    chk("xf_done_sv", bus.sout_valid, 0);
    chk("xf_done_sout", bus.sout, 0);
    @(negedge clk);
    chk("xf_ready_back", bus.load_ready, 1);
    chk("xf_idle_busy", bus.busy, 0);
    chk("xf_idle_done", bus.done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.abort      = 1'b0;
    clr_n = 1'b1;
    #1 clr_n = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_sout", bus.sout, 0);
      chk("rst_sout_valid", bus.sout_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_ready", bus.load_ready, 0);
    end
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("rel_ready", bus.load_ready, 1);
    chk("rel_busy", bus.busy, 0);
    @(negedge clk);

    xfer(8'hA5, 1'b0, 1'b0);

    // 0xFF held on load_valid while busy must only be taken at the next IDLE edge
    xfer(8'h3C, 1'b1, 1'b0);
    xfer(8'hFF, 1'b0, 1'b0);

    // accept beats abort in IDLE
    xfer(8'hC3, 1'b0, 1'b1);

    // abort during the 3rd bit
    chk("ab_ready", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hF0;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("ab_bit0", bus.sout, 1);
    @(negedge clk);
    chk("ab_bit1", bus.sout, 1);
    @(negedge clk);
    chk("ab_bit2", bus.sout, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab_sv", bus.sout_valid, 0);
    chk("ab_sout", bus.sout, 0);
    chk("ab_busy", bus.busy, 0);
    chk("ab_ready_back", bus.load_ready, 1);
    chk("ab_done", bus.done, 0);
    repeat (10) begin
      @(negedge clk);
      chk("ab_no_done", bus.done, 0);
      chk("ab_no_sv", bus.sout_valid, 0);
    end
    xfer(8'h5A, 1'b0, 1'b0);

    // reset dropped after the 2nd bit
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h81;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("mr_bit0", bus.sout, 1);
    @(negedge clk);
    chk("mr_bit1", bus.sout, 0);
    #2 clr_n = 1'b0;
    #1;
    chk("mr_sout", bus.sout, 0);
    chk("mr_sv", bus.sout_valid, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_ready", bus.load_ready, 0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("mr_no_done", bus.done, 0);
      chk("mr_no_sv", bus.sout_valid, 0);
      chk("mr_ready_idle", bus.load_ready, 1);
    end
    xfer(8'h81, 1'b0, 1'b0);

`ifdef SHIFT_OUT_CTRL_PARITY_EN
    xfer(8'h07, 1'b0, 1'b0);
    xfer(8'hA5, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
